// File: rtl/mac_pipe_if.sv
// Beat interface for mac_pipe: operand/valid inputs toward the MAC, result/flags back.
// Ports are plain vectors; mac_pipe applies the signed interpretation internally.
`timescale 1ns/1ps
interface mac_pipe_if #(
  parameter int A_DATA_WIDTH = 25,
  parameter int B_DATA_WIDTH = 18,
  parameter int C_DATA_WIDTH = 48,
  parameter int P_DATA_WIDTH = 48
) ();
  logic                    valid_in;
  logic                    load;
  logic [A_DATA_WIDTH-1:0] a;
  logic [B_DATA_WIDTH-1:0] b;
  logic [C_DATA_WIDTH-1:0] c;
  logic [P_DATA_WIDTH-1:0] p;
  logic                    valid_out;
  logic                    ovf;

  modport master (
    output valid_in, load, a, b, c,
    input  p, valid_out, ovf
  );

  modport slave (
    input  valid_in, load, a, b, c,
    output p, valid_out, ovf
  );
endinterface

// File: rtl/mac_pipe.sv
// Three-stage signed multiply-accumulate: p = c + a*b (load) or acc + a*b,
// with optional output clamping and a sticky per-group overflow flag.
`timescale 1ns/1ps
module mac_pipe #(
  parameter int A_DATA_WIDTH = 25,
  parameter int B_DATA_WIDTH = 18,
  parameter int C_DATA_WIDTH = 48,
  parameter int P_DATA_WIDTH = 48,
  parameter bit SATURATE     = 1'b1
) (
  input logic        clk,
  input logic        rst,
  mac_pipe_if.slave  bus
);

  localparam logic signed [47:0] P_MAX =
    {{(49-P_DATA_WIDTH){1'b0}}, {(P_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [47:0] P_MIN = ~P_MAX;

  // stage 1
  logic               v1;
  logic               load1;
  logic signed [24:0] a1;
  logic signed [17:0] b1;
  logic signed [47:0] c1;

  // stage 2
  logic               v2;
  logic               load2;
  logic signed [42:0] m2;
  logic signed [47:0] c2;

  // stage 3 / output
  logic signed [47:0]     acc;
  logic [P_DATA_WIDTH-1:0] p_q;
  logic                    ovf_q;
  logic                    valid_out_q;

  logic signed [47:0]      base;
  logic signed [47:0]      m_ext;
  logic signed [47:0]      sum;
  logic                    o48;
  logic                    op;
  logic                    clamp_hi;
  logic [P_DATA_WIDTH-1:0] p_next;
  logic                    ovf_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      load1 <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      c1    <= '0;
    end else begin
      v1 <= bus.valid_in;
      // operands only move when the beat is real, so idle inputs never toggle the datapath
      if (bus.valid_in) begin
        load1 <= bus.load;
        a1    <= 25'($signed(bus.a));
        b1    <= 18'($signed(bus.b));
        c1    <= 48'($signed(bus.c));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      load2 <= 1'b0;
      m2    <= '0;
      c2    <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        load2 <= load1;
        m2    <= 43'(a1) * 43'(b1);
        c2    <= c1;
      end
    end
  end

  always_comb begin
    base  = load2 ? c2 : acc;
    m_ext = 48'(m2);
    sum   = base + m_ext;
    o48   = (base[47] == m_ext[47]) && (sum[47] != base[47]);
    // never true at P=48 since P_MAX/P_MIN span the full 48-bit range
    op    = (sum > P_MAX) || (sum < P_MIN);
    // on 48-bit wrap the result sign is wrong, so the operand sign gives the true direction
    clamp_hi = o48 ? ~base[47] : ~sum[47];
    p_next   = sum[P_DATA_WIDTH-1:0];
    if (SATURATE && (o48 || op)) begin
      p_next = clamp_hi ? P_MAX[P_DATA_WIDTH-1:0] : P_MIN[P_DATA_WIDTH-1:0];
    end
    ovf_next = o48 | op | (~load2 & ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= v2;
      if (v2) begin
        acc   <= sum;
        p_q   <= p_next;
        ovf_q <= ovf_next;
      end
    end
  end

  assign bus.p         = p_q;
  assign bus.ovf       = ovf_q;
  assign bus.valid_out = valid_out_q;

endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
- Parametrised, fully pipelined signed multiply-accumulate; successor to the team's combinational DSP48E1 multiply-add.
- Computes either p = a*b + c (load) or p = acc + a*b (accumulate), with a valid handshake, fixed 3-cycle latency, optional output saturation and a per-group sticky overflow flag.
- Used in filter/FFT datapaths where the multiply-add must close timing at full fabric clock and partial sums span multiple samples.

Parameters:
- A_DATA_WIDTH, 25: signed a width; 2..25; sign-extended to 25.
- B_DATA_WIDTH, 18: signed b width; 2..18; sign-extended to 18.
- C_DATA_WIDTH, 48: signed c width; 2..48; sign-extended to 48.
- P_DATA_WIDTH, 48: signed p width; 2..48.
- SATURATE, 1: 1 = clamp p to the P range; 0 = p is the low P_DATA_WIDTH bits of acc.

Ports:
- clk  in  1  clock; all registers on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  a, b, c and load are sampled this cycle.
- load  in  1  1: acc = c + a*b (start of group); 0: acc = acc + a*b.
- a  in  A_DATA_WIDTH  signed multiplicand.
- b  in  B_DATA_WIDTH  signed multiplier.
- c  in  C_DATA_WIDTH  signed addend; used only when load=1.
- p  out  P_DATA_WIDTH  signed result.
- valid_out  out  1  p and ovf are valid this cycle.
- ovf  out  1  sticky overflow for the current accumulation group.

Behaviour:
- Reset: asynchronous clear of every pipeline register; p=0, valid_out=0, ovf=0, acc=0. Anything in flight is discarded. No valid_out appears for beats sampled before reset deassertion.
- Pipeline, for a beat sampled at edge k:
  - Stage 1 (edge k): register a, b and c sign-extended to 25/18/48 bits, plus load and valid.
  - Stage 2 (edge k+1): m = a_r*b_r, 43-bit signed, registered; c, load and valid delayed one stage.
  - Stage 3 (edge k+2): acc and p/ovf/valid_out registered.
  - valid_out is high for exactly one cycle after edge k+2. Latency is 3 cycles and constant.
- Throughput: one beat per cycle. No backpressure; the downstream must accept every valid_out.
- Bubbles: stages carry valid=0. acc, p and ovf hold their values while the stage-3 valid is 0. An accumulation group may span any number of bubbles.
- Stage-3 update, when the stage-3 valid is 1:
  - sum = (load ? c48 : acc) + sext48(m).
  - acc is 48-bit two's complement and wraps.
  - o48 = 1 if the 48-bit signed addition overflowed (operand signs equal, result sign differs).
  - oP = 1 if sum lies outside [-2^(P-1), 2^(P-1)-1]. oP is always 0 when P_DATA_WIDTH=48.
  - ovf_next = (o48 | oP), OR'd with the previous ovf when load=0.
  - p = SATURATE ? clamp(sum) : sum[P-1:0]. On o48 with SATURATE=1, clamp toward the sign of the true result: the sign of the addend operands.
- acc keeps the wrapped 48-bit value even when p saturates; saturation affects the output only.
- Load with no prior group: acc starts from c, independent of the old acc.
- load=1 on consecutive beats: each beat starts a new group; ovf does not carry across groups.
- valid_in=0: load, a, b and c are ignored.
- Width rules: a and b are always inside the 25x18 multiplier, so m never overflows. Only the accumulate step can overflow.

Test Plan:
- Reset mid-stream: valid_in=1 at edges 0..2, rst pulse at edge 2 -> valid_out stays 0 for 5 cycles; p=0, ovf=0 immediately on rst assertion, without waiting for a clock.
- Single load beat, a=3, b=-4, c=5 -> exactly one valid_out, 3 cycles later, with p=-7, ovf=0.
- Accumulate: load=1 with a=2, b=3, c=0; then load=0 with (4,5) and (-1,6); bubbles of 2 cycles between beats -> p sequence 6, 26, 20; valid_out pulses aligned 3 cycles after each beat.
- Saturation, P_DATA_WIDTH=16, SATURATE=1: load a=200, b=200, c=0 (40000) -> p=32767, ovf=1. Next load a=1, b=1, c=0 -> p=1, ovf=0.
- Sticky ovf and wrap, P_DATA_WIDTH=16, SATURATE=0: the 40000 case above -> p=-25536, ovf=1. Following accumulate of a=0, b=0 -> p=-25536, ovf stays 1.
- 48-bit overflow: load c=2^47-1, a=1, b=1 -> o48, p=2^47-1 (saturated), ovf=1, internal acc=-2^47. Full-rate back-to-back loads of random a, b, c -> p matches the reference model every cycle.
